data_line_sched: RTL and testbench
==================================

Name: data_line_sched

Overview:
- Sequencer and arbiter in front of one cache data array (byte-masked write port, registered read port with 1-cycle latency).
- Shares the array between three requesters:
  - CPU-side masked stores.
  - Burst line fills from memory.
  - Burst line reads for dirty-line writeback.
- Converts 64-bit memory beats to and from full-line array accesses with per-byte write masks.

Parameters:
s_offset, 5, log2 bytes per line (line = 256 bits, mask = 32 bits)
s_index, 3, log2 number of sets
s_beat, 64, bits per memory beat; beats per line NB = 8*2**s_offset/s_beat = 4

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
st_req  in  1  CPU store request (level)
st_index  in  s_index  store set index
st_mask  in  32  store byte enables
st_data  in  256  store data, line-aligned
st_ack  out  1  store written this cycle (combinational)
fill_start  in  1  start a fill (1-cycle pulse)
fill_index  in  s_index  fill set index
fill_beat_valid  in  1  fill beat present
fill_beat_data  in  64  fill beat
fill_beat_ready  out  1  fill beat accepted when valid&ready
fill_done  out  1  1-cycle pulse, fill complete
wb_start  in  1  start a writeback (1-cycle pulse)
wb_index  in  s_index  writeback set index
wb_beat_valid  out  1  writeback beat present
wb_beat_data  out  64  writeback beat
wb_beat_ready  in  1  consumer accepts beat
wb_done  out  1  1-cycle pulse, writeback complete
arr_read  out  1  array read enable
arr_load  out  1  array write enable
arr_write_en  out  32  array byte mask
arr_rindex  out  s_index  array read index
arr_windex  out  s_index  array write index
arr_datain  out  256  array write data
arr_dataout  in  256  array read data, valid 1 cycle after arr_read
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, FILL, WB_RD, WB_CAP, WB_SEND. Registers: state, beat counter cnt (2 bits, 0..NB-1), latched index, 256-bit wb buffer, done pulse flops.
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, buffer=0. All outputs 0. Array contents are not touched. Reset mid-burst abandons the burst; no done pulse is issued.
- IDLE priority: wb_start > fill_start > st_req.
  - wb_start: latch wb_index, go to WB_RD.
  - fill_start: latch fill_index, go to FILL.
  - Otherwise, if st_req: arr_load=1, arr_windex=st_index, arr_write_en=st_mask, arr_datain=st_data, st_ack=1 in the same cycle.
  - A start arriving with st_req in the same cycle wins; st_ack=0.
- Start pulses arriving while busy=1 are dropped.
- FILL:
  - fill_beat_ready=1.
  - Each accepted beat: arr_load=1, arr_windex=latched index, arr_write_en=8'hFF<<(8*cnt), arr_datain=beat replicated across all 4 lanes. Then cnt++.
  - On beat NB-1: cnt wraps to 0, next state IDLE, fill_done=1 for the following cycle.
  - Cycles with no valid beat are idle.
- Stores during FILL: allowed on cycles with fill_beat_valid=0 and st_index != latched index (same array drive, st_ack=1). Otherwise st_ack=0 and the store waits.
- WB_RD: arr_read=1, arr_rindex=latched index, for one cycle.
- WB_CAP: buffer <= arr_dataout. No array access.
- WB_SEND:
  - wb_beat_valid=1, wb_beat_data=buffer[64*cnt +: 64].
  - cnt++ on wb_beat_ready.
  - After beat NB-1: IDLE, wb_done pulse next cycle.
  - wb_beat_data is held stable while valid and not ready.
- Stores are blocked in all WB states (st_ack=0).
- When arr_load=0, arr_write_en, arr_windex and arr_datain are 0. When arr_read=0, arr_rindex is 0.
- Minimum latencies: fill = NB beats + 1 cycle to done; writeback = 2 cycles + NB beats + 1 cycle to done.

Test Plan:
- Store in IDLE: st_req, index 3, mask 32'h0000_000F, data 32'hDEADBEEF in byte 0..3 -> same cycle arr_load=1, arr_windex=3, arr_write_en=32'hF, st_ack=1.
- Fill, index 5, beats 64'h1111.., 64'h2222.., 64'h3333.., 64'h4444.. with 1 gap cycle after beat 1 -> arr_write_en FF, FF00, FF0000, FF000000 (per 8-bit groups) on the accepted cycles only; fill_done 1 cycle after beat 4; busy low the same cycle.
- Writeback, index 2; array returns line L; wb_beat_ready low for 2 cycles on beat 1 -> arr_read exactly once, beats L[63:0]..L[255:192] in order, data held while stalled, wb_done after the last handshake.
- Arbitration: wb_start, fill_start and st_req in the same IDLE cycle -> writeback runs, fill dropped, st_ack=0. Store to index 4 during a fill of index 6 on a no-beat cycle -> accepted. Store to index 6 -> stalled until IDLE.
- Reset mid-fill after 2 beats -> all outputs 0 immediately; no fill_done. A new fill after release starts at byte lane 0.

Source files
------------

// File: rtl/data_line_sched.sv
// data_line_sched: shares one cache data array between CPU stores, burst line fills and
// burst writeback reads, converting memory beats to and from full-line array accesses.
module data_line_sched #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_beat   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_req,
  input  logic [s_index-1:0]         st_index,
  input  logic [(1<<s_offset)-1:0]   st_mask,
  input  logic [(8<<s_offset)-1:0]   st_data,
  output logic                       st_ack,
  input  logic                       fill_start,
  input  logic [s_index-1:0]         fill_index,
  input  logic                       fill_beat_valid,
  input  logic [s_beat-1:0]          fill_beat_data,
  output logic                       fill_beat_ready,
  output logic                       fill_done,
  input  logic                       wb_start,
  input  logic [s_index-1:0]         wb_index,
  output logic                       wb_beat_valid,
  output logic [s_beat-1:0]          wb_beat_data,
  input  logic                       wb_beat_ready,
  output logic                       wb_done,
  output logic                       arr_read,
  output logic                       arr_load,
  output logic [(1<<s_offset)-1:0]   arr_write_en,
  output logic [s_index-1:0]         arr_rindex,
  output logic [s_index-1:0]         arr_windex,
  output logic [(8<<s_offset)-1:0]   arr_datain,
  input  logic [(8<<s_offset)-1:0]   arr_dataout,
  output logic                       busy
);
  localparam int lw = 8 << s_offset;
  localparam int mw = 1 << s_offset;
  localparam int nb = lw / s_beat;
  localparam int cw = (nb > 1) ? $clog2(nb) : 1;
  localparam int bb = s_beat / 8;
  localparam logic [mw-1:0] beat_mask = mw'({bb{1'b1}});
  typedef enum logic [2:0] {IDLE, FILL, WB_RD, WB_CAP, WB_SEND} state_t;
  state_t state_q, state_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [s_index-1:0] idx_q, idx_d;
  logic [lw-1:0] wbuf_q, wbuf_d;
  logic fill_done_q, fill_done_d, wb_done_q, wb_done_d;
  logic fill_acc, wb_acc, last, st_ok;
  assign last     = cnt_q == cw'(nb - 1);
  assign fill_acc = state_q == FILL && fill_beat_valid;
  assign wb_acc   = state_q == WB_SEND && wb_beat_ready;
  // a start pulse in IDLE claims the array ahead of a store; during a fill only beat-free
  // cycles to a different set may carry a store
  assign st_ok = rst && st_req &&
                 ((state_q == IDLE && !wb_start && !fill_start) ||
                  (state_q == FILL && !fill_beat_valid && st_index != idx_q));
  assign st_ack          = st_ok;
  assign fill_beat_ready = state_q == FILL;
  assign fill_done       = fill_done_q;
  assign wb_done         = wb_done_q;
  assign busy            = state_q != IDLE;
  assign arr_load        = fill_acc || st_ok;
  assign arr_windex      = fill_acc ? idx_q : st_ok ? st_index : '0;
  assign arr_write_en    = fill_acc ? beat_mask << (bb * cnt_q) : st_ok ? st_mask : '0;
  assign arr_datain      = fill_acc ? {nb{fill_beat_data}} : st_ok ? st_data : '0;
  assign arr_read        = state_q == WB_RD;
  assign arr_rindex      = arr_read ? idx_q : '0;
  assign wb_beat_valid   = state_q == WB_SEND;
  assign wb_beat_data    = wb_beat_valid ? wbuf_q[s_beat * cnt_q +: s_beat] : '0;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wbuf_d      = wbuf_q;
    fill_done_d = 1'b0;
    wb_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_start) begin
          idx_d   = wb_index;
          state_d = WB_RD;
        end else if (fill_start) begin
          idx_d   = fill_index;
          state_d = FILL;
        end
      end
      FILL: begin
        if (fill_acc) begin
          cnt_d       = last ? '0 : cnt_q + cw'(1);
          state_d     = last ? IDLE : FILL;
          fill_done_d = last;
        end
      end
      WB_RD:  state_d = WB_CAP;
      WB_CAP: begin
        wbuf_d  = arr_dataout;
        state_d = WB_SEND;
      end
      WB_SEND: begin
        if (wb_acc) begin
          cnt_d     = last ? '0 : cnt_q + cw'(1);
          state_d   = last ? IDLE : WB_SEND;
          wb_done_d = last;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wbuf_q      <= '0;
      fill_done_q <= 1'b0;
      wb_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wbuf_q      <= wbuf_d;
      fill_done_q <= fill_done_d;
      wb_done_q   <= wb_done_d;
    end
  end
endmodule

// File: tb/tb_data_line_sched.sv
// tb_data_line_sched: randomized directed steps against a line-level model of the cache array.
module tb_data_line_sched;
  typedef logic [383:0] v_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic st_req, st_ack, fill_start, fill_beat_valid, fill_beat_ready, fill_done;
  logic wb_start, wb_beat_valid, wb_beat_ready, wb_done, arr_read, arr_load, busy;
  logic [2:0] st_index, fill_index, wb_index, arr_rindex, arr_windex;
  logic [31:0] st_mask, arr_write_en;
  logic [255:0] st_data, arr_datain, arr_dataout;
  logic [63:0] fill_beat_data, wb_beat_data;
  logic [255:0] mem [8];
  logic [255:0] ref_line [8];
  logic load_mem = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int n_rd = 0;

  data_line_sched dut (
    .clk(clk), .rst(rst),
    .st_req(st_req), .st_index(st_index), .st_mask(st_mask), .st_data(st_data), .st_ack(st_ack),
    .fill_start(fill_start), .fill_index(fill_index), .fill_beat_valid(fill_beat_valid),
    .fill_beat_data(fill_beat_data), .fill_beat_ready(fill_beat_ready), .fill_done(fill_done),
    .wb_start(wb_start), .wb_index(wb_index), .wb_beat_valid(wb_beat_valid),
    .wb_beat_data(wb_beat_data), .wb_beat_ready(wb_beat_ready), .wb_done(wb_done),
    .arr_read(arr_read), .arr_load(arr_load), .arr_write_en(arr_write_en),
    .arr_rindex(arr_rindex), .arr_windex(arr_windex), .arr_datain(arr_datain),
    .arr_dataout(arr_dataout), .busy(busy)
  );

  function automatic logic [255:0] merge(input logic [255:0] line, input logic [31:0] m,
                                         input logic [255:0] d);
    for (int b = 0; b < 32; b++) if (m[b]) line[8*b +: 8] = d[8*b +: 8];
    return line;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic v_t all_outs();
    return v_t'({st_ack, fill_beat_ready, fill_done, wb_beat_valid, wb_beat_data, wb_done,
                 arr_read, arr_load, arr_write_en, arr_rindex, arr_windex, arr_datain, busy});
  endfunction

  // the cache data array the scheduler drives; read data appears one cycle after arr_read
  always @(posedge clk) begin
    if (load_mem) for (int i = 0; i < 8; i++) mem[i] <= ref_line[i];
    else if (arr_load) mem[arr_windex] <= merge(mem[arr_windex], arr_write_en, arr_datain);
    if (arr_read) begin
      arr_dataout <= mem[arr_rindex];
      n_rd <= n_rd + 1;
    end
  end

  task automatic chk(input string tag, input v_t got, input v_t exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    st_req = 1'b0; fill_start = 1'b0; wb_start = 1'b0;
    fill_beat_valid = 1'b0; wb_beat_ready = 1'b0;
  endtask

  task automatic chk_mem();
    @(negedge clk); idle(); #1;
    for (int i = 0; i < 8; i++) chk($sformatf("mem%0d", i), v_t'(mem[i]), v_t'(ref_line[i]));
  endtask

  task automatic store_idle(input logic [2:0] idx, input logic [31:0] m, input logic [255:0] d);
    @(negedge clk); idle();
    st_req = 1'b1; st_index = idx; st_mask = m; st_data = d; #1;
    chk("store_idle", v_t'({st_ack, arr_load, arr_windex, arr_write_en, arr_datain, busy}),
        v_t'({1'b1, 1'b1, idx, m, d, 1'b0}));
    ref_line[idx] = merge(ref_line[idx], m, d);
  endtask

  // gap cycles carry a store: first to another set (accepted), later to the fill set (held)
  task automatic do_fill(input logic [2:0] idx, input logic [255:0] line, input logic [3:0] gaps);
    logic pend, first;
    logic [2:0] pi;
    logic [31:0] pm;
    logic [255:0] pd;
    pend = 1'b0; first = 1'b1; pi = '0; pm = '0; pd = '0;
    @(negedge clk); idle(); fill_start = 1'b1; fill_index = idx; #1;
    chk("fill_start", v_t'({busy, arr_load}), v_t'(0));
    for (int i = 0; i < 4; i++) begin
      if (gaps[i]) begin
        @(negedge clk); idle();
        if (!pend) begin
          pend = 1'b1; pi = first ? idx ^ 3'd2 : idx; first = 1'b0;
          pm = $urandom; pd = rand256();
        end
        st_req = 1'b1; st_index = pi; st_mask = pm; st_data = pd; #1;
        chk("fill_gap", v_t'({st_ack, arr_load, fill_beat_ready, busy}),
            v_t'({pi != idx, pi != idx, 1'b1, 1'b1}));
        if (pi != idx) begin
          ref_line[pi] = merge(ref_line[pi], pm, pd);
          pend = 1'b0;
        end
      end
      @(negedge clk); idle();
      st_req = pend; fill_beat_valid = 1'b1; fill_beat_data = line[64*i +: 64]; #1;
      chk("fill_beat", v_t'({st_ack, fill_beat_ready, arr_load, busy, fill_done, arr_windex,
                             arr_write_en, arr_datain}),
          v_t'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, idx, 32'hFF << (8*i), {4{line[64*i +: 64]}}}));
    end
    @(negedge clk); idle(); st_req = pend; #1;
    chk("fill_done", v_t'({fill_done, busy, fill_beat_ready, st_ack, arr_load}),
        v_t'({1'b1, 1'b0, 1'b0, pend, pend}));
    ref_line[idx] = line;
    if (pend) begin
      chk("fill_held_store", v_t'(arr_windex), v_t'(idx));
      ref_line[idx] = merge(ref_line[idx], pm, pd);
    end
    @(negedge clk); idle(); #1;
    chk("fill_done_pulse", v_t'({fill_done, busy}), v_t'(0));
  endtask

  task automatic do_wb(input logic [2:0] idx, input logic [7:0] stalls, input bit arb);
    int rd0;
    logic [255:0] exp;
    @(negedge clk); idle(); wb_start = 1'b1; wb_index = idx;
    if (arb) begin
      fill_start = 1'b1; fill_index = $urandom;
      st_req = 1'b1; st_index = $urandom; st_mask = $urandom; st_data = rand256();
    end
    #1;
    rd0 = n_rd;
    exp = ref_line[idx];
    chk("wb_start", v_t'({st_ack, arr_load, arr_read, busy}), v_t'(0));
    @(negedge clk); idle(); #1;
    chk("wb_rd", v_t'({arr_read, arr_rindex, busy, wb_beat_valid, arr_load}),
        v_t'({1'b1, idx, 1'b1, 1'b0, 1'b0}));
    @(negedge clk); idle();
    if (arb) begin fill_start = 1'b1; st_req = 1'b1; end
    #1;
    chk("wb_cap", v_t'({arr_read, arr_load, st_ack, wb_beat_valid, busy}), v_t'(5'b00001));
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < int'(stalls[2*i +: 2]); s++) begin
        @(negedge clk); idle(); #1;
        chk("wb_stall", v_t'({wb_beat_valid, wb_beat_data, wb_done}),
            v_t'({1'b1, exp[64*i +: 64], 1'b0}));
      end
      @(negedge clk); idle(); wb_beat_ready = 1'b1; st_req = arb; #1;
      chk("wb_beat", v_t'({wb_beat_valid, wb_beat_data, st_ack, arr_load, wb_done}),
          v_t'({1'b1, exp[64*i +: 64], 3'b000}));
    end
    @(negedge clk); idle(); #1;
    chk("wb_done", v_t'({wb_done, busy, wb_beat_valid, n_rd - rd0}),
        v_t'({1'b1, 1'b0, 1'b0, 32'd1}));
    @(negedge clk); idle(); #1;
    chk("wb_after", v_t'({wb_done, busy}), v_t'(0));
  endtask

  initial begin
    logic [255:0] line, d;
    idle();
    st_index = '0; st_mask = '0; st_data = '0; fill_index = '0; wb_index = '0;
    fill_beat_data = '0;
    for (int i = 0; i < 8; i++) ref_line[i] = rand256();
    st_req = 1'b1; st_mask = '1; fill_beat_valid = 1'b1; load_mem = 1'b1;
    @(negedge clk); #1;
    chk("reset_outs", all_outs(), v_t'(0));
    @(negedge clk); idle(); load_mem = 1'b0; rst = 1'b1;
    chk_mem();

    d = rand256(); d[31:0] = 32'hDEADBEEF;
    store_idle(3'd3, 32'h0000_000F, d);
    for (int k = 0; k < 6; k++) store_idle(3'($urandom), $urandom, rand256());
    chk_mem();

    line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_fill(3'd5, line, 4'b0010);
    chk_mem();
    do_wb(3'd2, 8'b0000_1000, 1'b0);
    do_wb(3'($urandom), 8'($urandom), 1'b1);
    chk_mem();
    do_fill(3'd6, rand256(), 4'b0110);
    chk_mem();
    do_wb(3'd6, 8'($urandom), 1'b0);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 2))
        0: do_fill(3'($urandom), rand256(), 4'($urandom));
        1: do_wb(3'($urandom), 8'($urandom), 1'($urandom));
        default: store_idle(3'($urandom), $urandom, rand256());
      endcase
      chk_mem();
    end

    line = rand256();
    @(negedge clk); idle(); fill_start = 1'b1; fill_index = 3'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); fill_beat_valid = 1'b1; fill_beat_data = line[64*i +: 64];
    end
    @(negedge clk); idle();
    fill_beat_valid = 1'b1; fill_beat_data = line[127:64];
    st_req = 1'b1; st_index = 3'd3; st_mask = '1; rst = 1'b0; #1;
    chk("rst_mid_fill", all_outs(), v_t'(0));
    ref_line[1][127:0] = line[127:0];
    @(negedge clk); #1;
    chk("rst_hold", all_outs(), v_t'(0));
    @(negedge clk); idle(); rst = 1'b1; #1;
    chk("rst_release", v_t'({fill_done, busy, fill_beat_ready, st_ack}), v_t'(0));
    @(negedge clk); #1;
    chk("rst_no_done", v_t'({fill_done, busy}), v_t'(0));
    chk_mem();
    do_fill(3'd1, rand256(), 4'b0000);
    chk_mem();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
